mem_bist_ctrl: RTL and testbench
================================

// Module: mem_bist_ctrl
// PURPOSE
//   Initiator-side built-in self-test engine for the single-port sync RAM (we/addr/din/dout, 1-cycle registered read).
//   Drives mem_we/mem_addr/mem_din, checks mem_dout against an address-derived pattern, reports pass/fail.
//   Sits between top-level control (start/status) and one RAM instance; owns the RAM port while busy.
// PARAMETERS
//   ADDR_W  10             RAM address width
//   DATA_W  32             RAM data width
//   DEPTH   1024           words tested, addresses 0..DEPTH-1 (DEPTH <= 2**ADDR_W)
//   SEED    32'hA5A5_0000  pattern base; P(a) = (SEED + a) mod 2**DATA_W
// PORTS
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous reset, active-high
//   start      in   1       begin test; sampled in IDLE or DONE, ignored while busy
//   mem_we     out  1       RAM write enable
//   mem_addr   out  ADDR_W  RAM address
//   mem_din    out  DATA_W  RAM write data
//   mem_dout   in   DATA_W  RAM read data, valid 1 cycle after a read issue (mem_we=0)
//   busy       out  1       test in progress
//   done       out  1       test finished; level, held until next start or rst
//   pass       out  1       valid while done: 1 = zero mismatches
//   err_count  out  16      mismatch count, saturates at 16'hFFFF
//   fail_addr  out  ADDR_W  address of first mismatch
//   fail_data  out  DATA_W  data read at first mismatch
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0 (mem_we, mem_addr, mem_din, busy, done, pass, err_count, fail_addr, fail_data).
//   All outputs registered. States: IDLE, WR0, RD0, DRN0, WR1, RD1, DRN1, DONE.
//   IDLE/DONE --start--> WR0; clears err_count, fail_addr, fail_data, done, pass; busy=1 from next cycle.
//   WR0: one write per cycle, addr 0..DEPTH-1 ascending, mem_we=1, mem_din=P(addr); after DEPTH-1 -> RD0.
//   RD0: one read per cycle, addr 0..DEPTH-1, mem_we=0, mem_din=0; after DEPTH-1 -> DRN0.
//   Compare pipeline: issued addr and expected data delayed 1 cycle; compare mem_dout next cycle.
//   DRN0: 1 cycle, no issue, compares last read only.
//   WR1/RD1/DRN1: as WR0/RD0/DRN0 with expected/written data ~P(addr) (only with macro, see below).
//   Mismatch: err_count += 1 (saturating); on first mismatch of run latch fail_addr, fail_data.
//   After final drain -> DONE: busy=0, done=1, pass=(err_count==0) incl. any final-cycle increment.
//   IDLE/DONE: mem_we=0, mem_addr=0, mem_din=0. Address counter never exceeds DEPTH-1.
//   start while busy: ignored, no restart. rst mid-run: IDLE next edge, mem_we=0, results cleared.
//   Simultaneous start and rst: rst wins.
//   Run length (start sampled -> done=1): 2*DEPTH+2 cycles base; 4*DEPTH+3 with macro.
// CONFIGURATION
//   MEM_BIST_INV_PASS_EN defined: after DRN0 run WR1, RD1, DRN1 (inverted pattern, catches stuck-at-1/0 on all bits).
//   Undefined: DRN0 -> DONE directly; WR1/RD1/DRN1 logic not compiled.
// TESTING
//   Bench uses behavioural RAM model, 1-cycle registered read, dout held on write cycles; DEPTH=1024.
//   1 Fault-free RAM, pulse start -> busy 1 for run, done=1, pass=1, err_count=0;
//     done at cycle 2050 (no macro) / 4099 (macro).
//   2 Model forces dout bit0=1 when read addr==4 -> R0 reads A5A5_0005 vs A5A5_0004;
//     err_count=1 both builds, fail_addr=4, fail_data=32'hA5A5_0005, pass=0.
//   3 Model forces dout bit0=0 at addr 4 -> no macro: pass=1;
//     macro: R1 mismatch (expect 5A5A_FFFB), err_count=1, fail_addr=4, fail_data=32'h5A5A_FFFA.
//   4 Model returns 0 on every read -> err_count=1024 (no macro) / 2048 (macro), fail_addr=0, fail_data=0.
//   5 Assert rst at cycle 500 of WR0 -> next cycle: mem_we=0, busy=0, done=0, err_count=0;
//     restart with start -> full pass=1.
//   6 Pulse start again at cycle 100 of RD0 -> ignored, run completes on original schedule;
//     start while DONE -> new run, done drops next cycle.

Source files
------------

// File: rtl/mem_bist_ctrl.sv
// mem_bist_ctrl: write/read-back BIST engine for a single-port RAM with a 1-cycle registered read.
// Optional build macro MEM_BIST_INV_PASS_EN adds a second pass using the inverted address pattern.
module mem_bist_ctrl #(
    parameter int                ADDR_W = 10,
    parameter int                DATA_W = 32,
    parameter int                DEPTH  = 1024,
    parameter logic [DATA_W-1:0] SEED   = 32'hA5A5_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR0  = 3'd1,
        ST_RD0  = 3'd2,
        ST_DRN0 = 3'd3,
        ST_WR1  = 3'd4,
        ST_RD1  = 3'd5,
        ST_DRN1 = 3'd6,
        ST_DONE = 3'd7
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a, input logic inv);
        logic [DATA_W-1:0] p;
        p = SEED + DATA_W'(a);
        return inv ? ~p : p;
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic                rd_q, rd_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [DATA_W-1:0]   exp_q, exp_d;
    logic                cmp_vld_q;
    logic [ADDR_W-1:0]   cmp_addr_q;
    logic [DATA_W-1:0]   cmp_exp_q;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [15:0]         err_q, err_d;
    logic [ADDR_W-1:0]   faddr_q, faddr_d;
    logic [DATA_W-1:0]   fdata_q, fdata_d;
    logic                start_acc;
    logic                mismatch;
    logic                inv_pass;

    // Sequencer: walks the address counter through each write, read and drain phase.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        start_acc = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = ST_WR0;
                    addr_d    = ZERO_ADDR;
                end else begin
                    state_d   = state_q;
                end
            end
            ST_WR0: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_RD0;
                    addr_d  = ZERO_ADDR;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
            ST_RD0: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DRN0;
                    addr_d  = ZERO_ADDR;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
`ifdef MEM_BIST_INV_PASS_EN
            ST_DRN0: state_d = ST_WR1;
            ST_WR1: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_RD1;
                    addr_d  = ZERO_ADDR;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
            ST_RD1: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DRN1;
                    addr_d  = ZERO_ADDR;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
            ST_DRN1: state_d = ST_DONE;
`else
            ST_DRN0: state_d = ST_DONE;
`endif
            default: begin
                state_d = ST_IDLE;
                addr_d  = ZERO_ADDR;
            end
        endcase
    end

    // RAM port is registered from the next state so each access leaves on the edge that enters it.
    always_comb begin
        we_d     = 1'b0;
        rd_d     = 1'b0;
        maddr_d  = ZERO_ADDR;
        din_d    = ZERO_DATA;
        exp_d    = ZERO_DATA;
        inv_pass = 1'b0;
`ifdef MEM_BIST_INV_PASS_EN
        if (state_d == ST_WR1 || state_d == ST_RD1) begin
            inv_pass = 1'b1;
        end else begin
            inv_pass = 1'b0;
        end
`endif
        case (state_d)
            ST_WR0, ST_WR1: begin
                we_d    = 1'b1;
                maddr_d = addr_d;
                din_d   = pattern(addr_d, inv_pass);
            end
            ST_RD0, ST_RD1: begin
                rd_d    = 1'b1;
                maddr_d = addr_d;
                exp_d   = pattern(addr_d, inv_pass);
            end
            default: begin
                we_d    = 1'b0;
                rd_d    = 1'b0;
            end
        endcase
    end

    // Result bookkeeping; pass is judged on the count that includes the final drain compare.
    always_comb begin
        err_d    = err_q;
        faddr_d  = faddr_q;
        fdata_d  = fdata_q;
        mismatch = cmp_vld_q && (mem_dout != cmp_exp_q);
        if (start_acc) begin
            err_d   = 16'd0;
            faddr_d = ZERO_ADDR;
            fdata_d = ZERO_DATA;
        end else if (mismatch) begin
            if (err_q != 16'hFFFF) begin
                err_d = err_q + 16'd1;
            end else begin
                err_d = err_q;
            end
            if (err_q == 16'd0) begin
                faddr_d = cmp_addr_q;
                fdata_d = mem_dout;
            end else begin
                faddr_d = faddr_q;
                fdata_d = fdata_q;
            end
        end else begin
            err_d = err_q;
        end
        busy_d = !(state_d == ST_IDLE || state_d == ST_DONE);
        done_d = (state_d == ST_DONE);
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            pass_d = (err_d == 16'd0);
        end else if (state_d == ST_DONE) begin
            pass_d = pass_q;
        end else begin
            pass_d = 1'b0;
        end
    end

    // State register and address counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= ZERO_ADDR;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Registered RAM port, one-deep compare pipeline and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            rd_q       <= 1'b0;
            maddr_q    <= ZERO_ADDR;
            din_q      <= ZERO_DATA;
            exp_q      <= ZERO_DATA;
            cmp_vld_q  <= 1'b0;
            cmp_addr_q <= ZERO_ADDR;
            cmp_exp_q  <= ZERO_DATA;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= 16'd0;
            faddr_q    <= ZERO_ADDR;
            fdata_q    <= ZERO_DATA;
        end else begin
            we_q       <= we_d;
            rd_q       <= rd_d;
            maddr_q    <= maddr_d;
            din_q      <= din_d;
            exp_q      <= exp_d;
            cmp_vld_q  <= rd_q;
            cmp_addr_q <= maddr_q;
            cmp_exp_q  <= exp_q;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            faddr_q    <= faddr_d;
            fdata_q    <= fdata_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = maddr_q;
    assign mem_din   = din_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_addr = faddr_q;
    assign fail_data = fdata_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: fault-injecting RAM model plus a cycle-level reference of the expected BIST behaviour.
// Honours MEM_BIST_INV_PASS_EN the same way the design does.
module tb_mem_bist_ctrl;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1024;
    localparam logic [31:0] SEED = 32'hA5A5_0000;
`ifdef MEM_BIST_INV_PASS_EN
    localparam int NPASS     = 2;
    localparam int DONE_CYC  = 4099;
    localparam int ZERO_ERRS = 2048;
`else
    localparam int NPASS     = 1;
    localparam int DONE_CYC  = 2050;
    localparam int ZERO_ERRS = 1024;
`endif
    localparam int PASS_LEN = 2 * DEPTH + 1;
    localparam int RUN_L    = NPASS * PASS_LEN;

    logic              clk;
    logic              rst;
    logic              start;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic              busy;
    logic              done;
    logic              pass;
    logic [15:0]       err_count;
    logic [ADDR_W-1:0] fail_addr;
    logic [DATA_W-1:0] fail_data;

    int n_checks = 0;
    int n_fail   = 0;

    mem_bist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_addr(fail_addr), .fail_data(fail_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fault injection: 0 none, 1 force bit high at f_addr, 2 force bit low at f_addr, 3 all reads zero
    int f_mode = 0;
    int f_addr = 0;
    int f_bit  = 0;

    function automatic logic [31:0] apply_fault(input logic [31:0] v, input int a);
        logic [31:0] r;
        r = v;
        if (f_mode == 3) r = 32'h0;
        else if (f_mode == 1 && a == f_addr) r[f_bit] = 1'b1;
        else if (f_mode == 2 && a == f_addr) r[f_bit] = 1'b0;
        return r;
    endfunction

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    initial mem_dout = '0;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        else mem_dout <= apply_fault(ram[mem_addr], int'(mem_addr));
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h, required %h (time %0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_pat(input int a, input int p);
        logic [31:0] v;
        v = SEED + 32'(a);
        return (p != 0) ? ~v : v;
    endfunction

    // What the RAM port does t cycles after the start-sampling edge: 0 idle, 1 write, 2 read
    function automatic void phase_of(input int t, output int kind, output int a, output int p);
        int u;
        kind = 0; a = 0;
        p = t / PASS_LEN;
        u = t % PASS_LEN;
        if (t >= 0 && t < RUN_L) begin
            if (u < DEPTH) begin kind = 1; a = u; end
            else if (u < 2 * DEPTH) begin kind = 2; a = u - DEPTH; end
        end
    endfunction

    // Reference model state
    bit          m_armed = 0;
    bit          m_run   = 0;
    int          m_t     = 0;
    int          m_err   = 0;
    int          m_faddr = 0;
    logic [31:0] m_fdata = 32'h0;

    always @(posedge clk) begin
        int kind, a, p;
        logic [31:0] e, rv;
        logic e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [31:0] e_din;
        if (rst) begin
            m_armed = 1; m_run = 0; m_t = 0; m_err = 0; m_faddr = 0; m_fdata = 32'h0;
        end else if (m_armed) begin
            if (start && (!m_run || m_t >= RUN_L)) begin
                m_run = 1; m_t = 0; m_err = 0; m_faddr = 0; m_fdata = 32'h0;
            end else if (m_run) begin
                m_t++;
                // a read issued at time tr is scored two edges later
                phase_of(m_t - 2, kind, a, p);
                if (m_t >= 2 && kind == 2) begin
                    e  = ref_pat(a, p);
                    rv = apply_fault(e, a);
                    if (rv !== e) begin
                        if (m_err == 0) begin m_faddr = a; m_fdata = rv; end
                        if (m_err < 65535) m_err++;
                    end
                end
            end
        end
        #1;
        if (m_armed) begin
            e_we = 1'b0; e_addr = '0; e_din = 32'h0;
            if (m_run) begin
                phase_of(m_t, kind, a, p);
                if (kind != 0) e_addr = ADDR_W'(a);
                if (kind == 1) begin e_we = 1'b1; e_din = ref_pat(a, p); end
            end
            check("mem_we", mem_we, e_we);
            check("mem_addr", mem_addr, e_addr);
            check("mem_din", mem_din, e_din);
            check("busy", busy, m_run && m_t < RUN_L);
            check("done", done, m_run && m_t >= RUN_L);
            check("pass", pass, m_run && m_t >= RUN_L && m_err == 0);
            check("err_count", err_count, m_err);
            check("fail_addr", fail_addr, m_faddr);
            check("fail_data", fail_data, m_fdata);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_done", done, 1'b1);
    endtask

    task automatic run_fault(input int mode, input int fa, input int fb);
        f_mode = mode; f_addr = fa; f_bit = fb;
        pulse_start();
        wait_done(DONE_CYC + 8);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_err", err_count, 16'd0);
        rst = 1'b0;

        // fault-free run with exact completion cycle
        pulse_start();
        repeat (DONE_CYC - 2) @(negedge clk);
        check("t1_done_early", done, 1'b0);
        check("t1_busy_early", busy, 1'b1);
        @(negedge clk);
        check("t1_done_on_time", done, 1'b1);
        check("t1_busy_end", busy, 1'b0);
        check("t1_pass", pass, 1'b1);
        check("t1_err", err_count, 16'd0);

        // bit0 stuck high at address 4
        run_fault(1, 4, 0);
        check("t2_err", err_count, 16'd1);
        check("t2_faddr", fail_addr, 10'd4);
        check("t2_fdata", fail_data, 32'hA5A5_0005);
        check("t2_pass", pass, 1'b0);

        // bit0 stuck low at address 4
        run_fault(2, 4, 0);
`ifdef MEM_BIST_INV_PASS_EN
        check("t3_err", err_count, 16'd1);
        check("t3_faddr", fail_addr, 10'd4);
        check("t3_fdata", fail_data, 32'h5A5A_FFFA);
        check("t3_pass", pass, 1'b0);
`else
        check("t3_err", err_count, 16'd0);
        check("t3_pass", pass, 1'b1);
`endif

        // every read returns zero
        run_fault(3, 0, 0);
        check("t4_err", err_count, 16'(ZERO_ERRS));
        check("t4_faddr", fail_addr, 10'd0);
        check("t4_fdata", fail_data, 32'h0);
        check("t4_pass", pass, 1'b0);

        // reset in the middle of the write phase, then a clean rerun
        f_mode = 0;
        pulse_start();
        repeat (499) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_we", mem_we, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_done", done, 1'b0);
        check("t5_err", err_count, 16'd0);
        pulse_start();
        wait_done(DONE_CYC + 8);
        check("t5_pass", pass, 1'b1);

        // start while busy is ignored; start while done restarts
        pulse_start();
        repeat (DEPTH + 99) @(negedge clk);
        pulse_start();
        repeat (DONE_CYC - (DEPTH + 101) - 1) @(negedge clk);
        check("t6_done_early", done, 1'b0);
        @(negedge clk);
        check("t6_done_on_time", done, 1'b1);
        pulse_start();
        check("t6_done_dropped", done, 1'b0);
        check("t6_busy_restart", busy, 1'b1);
        wait_done(DONE_CYC + 8);
        check("t6_pass", pass, 1'b1);

        // random single-bit faults with a stray start during the run
        for (int i = 0; i < 4; i++) begin
            f_mode = int'($urandom_range(1, 2));
            f_addr = int'($urandom_range(0, DEPTH - 1));
            f_bit  = int'($urandom_range(0, 31));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            pulse_start();
            repeat ($urandom_range(10, 1500)) @(negedge clk);
            pulse_start();
            wait_done(DONE_CYC + 8);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
